// File: rtl/lcd_cmd_pkg.sv
// Shared types and constants for the PMOD CLS command sequencer.
// Covers FSM states, command codes, line text, escape bytes and sequence lengths.
package lcd_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP,
      ST_DONE
   } t_lcd_cmd_state;

   typedef enum logic [1:0] {
      CMD_CLEAR,
      CMD_LINE1,
      CMD_LINE2
   } t_lcd_cmd;

   typedef logic [127:0] t_lcd_line_text;

   localparam logic [7:0] c_esc       = 8'h1B;
   localparam logic [7:0] c_bracket   = 8'h5B;
   localparam logic [7:0] c_clear     = 8'h6A;
   localparam logic [7:0] c_semicolon = 8'h3B;
   localparam logic [7:0] c_home      = 8'h48;
   localparam logic [7:0] c_row1      = 8'h30;
   localparam logic [7:0] c_row2      = 8'h31;
   localparam logic [7:0] c_col0      = 8'h30;

   localparam logic [4:0] c_len_clear = 5'd3;
   localparam logic [4:0] c_len_line  = 5'd22;

   // Number of header bytes ahead of the text in a line command
   localparam logic [4:0] c_len_hdr   = 5'd6;

   function automatic logic [4:0] f_seq_len(input t_lcd_cmd cmd);
      return (cmd == CMD_CLEAR) ? c_len_clear : c_len_line;
   endfunction

   // Escape/position bytes; the third byte selects clear or the target row
   function automatic logic [7:0] f_header_byte(input t_lcd_cmd cmd, input logic [4:0] idx);
      logic [7:0] b;
      case (idx)
         5'd0:    b = c_esc;
         5'd1:    b = c_bracket;
         5'd2:    b = (cmd == CMD_CLEAR) ? c_clear : ((cmd == CMD_LINE2) ? c_row2 : c_row1);
         5'd3:    b = c_semicolon;
         5'd4:    b = c_col0;
         5'd5:    b = c_home;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_char_filter.sv
// Printable-ASCII substitution for text bytes (module lcd_char_filter).
// Only built when LCD_CMD_SEQ_CHAR_FILTER_EN is defined, so the default
// build carries no unused module.
`ifdef LCD_CMD_SEQ_CHAR_FILTER_EN
module lcd_char_filter (
   input  logic [7:0] i_char,
   output logic [7:0] o_char
);

   // Non-printable characters are replaced by a space
   always_comb begin
      o_char = ((i_char < 8'h20) || (i_char > 8'h7E)) ? 8'h20 : i_char;
   end

endmodule
`endif

// File: rtl/lcd_cmd_sequencer.sv
// Expands clear / line-write commands into PMOD CLS escape sequences and
// streams them over a valid/ready byte interface with a programmable gap.
// Optional feature: LCD_CMD_SEQ_CHAR_FILTER_EN replaces non-printable text
// bytes with 0x20; header bytes are never filtered.
module lcd_cmd_sequencer #(
   parameter int parm_gap_ce = 25
) (
   input  logic         i_clk_20mhz,
   input  logic         i_rst_20mhz,
   input  logic         i_ce_2_5mhz,
   input  logic         i_wr_clear_display,
   input  logic         i_wr_text_line1,
   input  logic         i_wr_text_line2,
   input  logic [127:0] i_dat_ascii_line1,
   input  logic [127:0] i_dat_ascii_line2,
   output logic         o_command_ready,
   output logic [7:0]   o_tx_byte,
   output logic         o_tx_valid,
   input  logic         i_tx_ready,
   output logic         o_tx_last
);
   import lcd_cmd_pkg::*;

   localparam int GAP_W = (parm_gap_ce > 1) ? $clog2(parm_gap_ce + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(parm_gap_ce);

   t_lcd_cmd_state state_q, state_d;
   t_lcd_cmd       cmd_q, cmd_d;
   t_lcd_line_text text_q, text_d;
   logic [4:0]     idx_q, idx_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [7:0]     tx_byte_q, tx_byte_d;
   logic           tx_valid_q, tx_valid_d;
   logic           tx_last_q, tx_last_d;

   logic [3:0]     char_off;
   logic [6:0]     char_lsb;
   logic [7:0]     char_raw;
   logic [7:0]     char_tx;

   // Sequencer next-state: accept, per-byte advance, gap countdown, done
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      text_d  = text_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      if (i_ce_2_5mhz) begin
         case (state_q)
            ST_IDLE: begin
               if (i_wr_clear_display || i_wr_text_line1 || i_wr_text_line2) begin
                  if (i_wr_clear_display)   cmd_d = CMD_CLEAR;
                  else if (i_wr_text_line1) cmd_d = CMD_LINE1;
                  else                      cmd_d = CMD_LINE2;
                  text_d  = (cmd_d == CMD_LINE2) ? i_dat_ascii_line2 : i_dat_ascii_line1;
                  idx_d   = 5'd0;
                  state_d = ST_SEND;
               end
            end
            ST_SEND: begin
               if (tx_valid_q && i_tx_ready) begin
                  if (idx_q == (f_seq_len(cmd_q) - 5'd1)) begin
                     state_d = ST_DONE;
                  end else begin
                     idx_d = idx_q + 5'd1;
                     if (parm_gap_ce > 0) begin
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                     end
                  end
               end
            end
            ST_GAP: begin
               gap_d = gap_q - GAP_W'(1);
               if (gap_q <= GAP_W'(1)) state_d = ST_SEND;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Pick the text character addressed by the next index (idx 6..21 -> char 0..15)
   always_comb begin
      char_off = idx_d[3:0] - 4'd6;
      char_lsb = {4'd15 - char_off, 3'b000};
      char_raw = text_d[char_lsb +: 8];
   end

`ifdef LCD_CMD_SEQ_CHAR_FILTER_EN
   lcd_char_filter u_char_filter (
      .i_char (char_raw),
      .o_char (char_tx)
   );
`else
   assign char_tx = char_raw;
`endif

   // Registered byte-stream outputs derived from the next state and index
   always_comb begin
      tx_valid_d = (state_d == ST_SEND);
      tx_byte_d  = 8'h00;
      tx_last_d  = 1'b0;
      if (tx_valid_d) begin
         if ((cmd_d == CMD_CLEAR) || (idx_d < c_len_hdr)) tx_byte_d = f_header_byte(cmd_d, idx_d);
         else                                             tx_byte_d = char_tx;
         tx_last_d = (idx_d == (f_seq_len(cmd_d) - 5'd1));
      end
   end

   // Control and output registers; reset abandons any sequence in flight
   always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
      if (i_rst_20mhz) begin
         state_q    <= ST_IDLE;
         cmd_q      <= CMD_CLEAR;
         idx_q      <= 5'd0;
         gap_q      <= '0;
         tx_byte_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         tx_byte_q  <= tx_byte_d;
         tx_valid_q <= tx_valid_d;
         tx_last_q  <= tx_last_d;
      end
   end

   // Text snapshot is pure data and needs no reset
   always_ff @(posedge i_clk_20mhz) begin
      text_q <= text_d;
   end

   assign o_command_ready = (state_q == ST_IDLE);
   assign o_tx_byte       = tx_byte_q;
   assign o_tx_valid      = tx_valid_q;
   assign o_tx_last       = tx_last_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed scoreboard bench for lcd_cmd_sequencer (gap 0 and default gap 25).
module tb_lcd_cmd_sequencer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ce  = 1'b0;
   logic         wr_clr = 1'b0, wr_l1 = 1'b0, wr_l2 = 1'b0;
   logic [127:0] l1 = '0, l2 = '0;
   logic         ready = 1'b1;
   logic         cmd_rdy, tx_valid, tx_last;
   logic [7:0]   tx_byte;

   logic         g_wr_clr = 1'b0;
   logic         g_rdy, g_valid, g_last;
   logic [7:0]   g_byte;

   int           n_cmp = 0;
   int           n_err = 0;
   logic [8:0]   sb[$];
   int           t;
   int           cnt;

   always #5 clk = ~clk;

   initial begin
      int k;
      k = 0;
      forever begin
         @(negedge clk);
         k = (k + 1) % 4;
         ce = (k == 0);
      end
   end

   lcd_cmd_sequencer #(.parm_gap_ce(0)) dut (
      .i_clk_20mhz        (clk),
      .i_rst_20mhz        (rst),
      .i_ce_2_5mhz        (ce),
      .i_wr_clear_display (wr_clr),
      .i_wr_text_line1    (wr_l1),
      .i_wr_text_line2    (wr_l2),
      .i_dat_ascii_line1  (l1),
      .i_dat_ascii_line2  (l2),
      .o_command_ready    (cmd_rdy),
      .o_tx_byte          (tx_byte),
      .o_tx_valid         (tx_valid),
      .i_tx_ready         (ready),
      .o_tx_last          (tx_last)
   );

   lcd_cmd_sequencer dut_g (
      .i_clk_20mhz        (clk),
      .i_rst_20mhz        (rst),
      .i_ce_2_5mhz        (ce),
      .i_wr_clear_display (g_wr_clr),
      .i_wr_text_line1    (1'b0),
      .i_wr_text_line2    (1'b0),
      .i_dat_ascii_line1  (l1),
      .i_dat_ascii_line2  (l2),
      .o_command_ready    (g_rdy),
      .o_tx_byte          (g_byte),
      .o_tx_valid         (g_valid),
      .i_tx_ready         (1'b1),
      .o_tx_last          (g_last)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next enabled clock edge
   task automatic tick();
      do @(posedge clk); while (!ce);
      #1;
   endtask

   function automatic logic [7:0] flt(input logic [7:0] c);
`ifdef LCD_CMD_SEQ_CHAR_FILTER_EN
      return ((c < 8'h20) || (c > 8'h7E)) ? 8'h20 : c;
`else
      return c;
`endif
   endfunction

   task automatic push_clear();
      sb.push_back({1'b0, 8'h1B});
      sb.push_back({1'b0, 8'h5B});
      sb.push_back({1'b1, 8'h6A});
   endtask

   task automatic push_line(input bit second, input logic [127:0] txt);
      logic [7:0] c;
      sb.push_back({1'b0, 8'h1B});
      sb.push_back({1'b0, 8'h5B});
      sb.push_back({1'b0, second ? 8'h31 : 8'h30});
      sb.push_back({1'b0, 8'h3B});
      sb.push_back({1'b0, 8'h30});
      sb.push_back({1'b0, 8'h48});
      for (int i = 0; i < 16; i++) begin
         c = txt[127 - 8*i -: 8];
         sb.push_back({(i == 15), flt(c)});
      end
   endtask

   // Consume n accepted bytes from the gap-0 instance, comparing against the scoreboard
   task automatic collect(input int n, input string tag, output int ticks);
      int got;
      logic [8:0] e;
      got = 0;
      ticks = 0;
      while (got < n && ticks < 300) begin
         if (tx_valid && ready) begin
            e = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
            chk({tag, "_byte"}, {24'h0, tx_byte}, {24'h0, e[7:0]});
            chk({tag, "_last"}, {31'h0, tx_last}, {31'h0, e[8]});
            got++;
         end
         tick();
         ticks++;
      end
      chk({tag, "_count"}, got, n);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'h0, cmd_rdy}, 1);
      chk("rst_valid", {31'h0, tx_valid}, 0);
      chk("rst_byte",  {24'h0, tx_byte}, 0);
      chk("rst_last",  {31'h0, tx_last}, 0);
      chk("rst_g_ready", {31'h0, g_rdy}, 1);
      rst = 1'b0;
      tick();

      // Clear, gap 0, back-to-back bytes
      push_clear();
      wr_clr = 1'b1;
      tick();
      wr_clr = 1'b0;
      chk("clr_ready_low", {31'h0, cmd_rdy}, 0);
      chk("clr_valid_high", {31'h0, tx_valid}, 1);
      collect(3, "clr", t);
      chk("clr_ticks", t, 3);
      chk("clr_done_ready", {31'h0, cmd_rdy}, 0);
      tick();
      chk("clr_idle_ready", {31'h0, cmd_rdy}, 1);

      // Line 2 with snapshot; input changed mid-stream
      l2 = "X+0.12 Y-0.03 Z1";
      push_line(1'b1, l2);
      wr_l2 = 1'b1;
      tick();
      wr_l2 = 1'b0;
      l2 = "ABCDEFGHIJKLMNOP";
      collect(22, "l2", t);
      tick();
      chk("l2_idle_ready", {31'h0, cmd_rdy}, 1);

      // Clear and line 1 together: clear wins, line 1 dropped
      l1 = "Hello, PMOD CLS!";
      push_clear();
      wr_clr = 1'b1;
      wr_l1  = 1'b1;
      tick();
      wr_clr = 1'b0;
      wr_l1  = 1'b0;
      collect(3, "pri", t);
      tick();
      chk("pri_ready", {31'h0, cmd_rdy}, 1);
      repeat (3) tick();
      chk("pri_no_more_valid", {31'h0, tx_valid}, 0);
      chk("pri_sb_empty", sb.size(), 0);

      // Backpressure on byte 4 of line 1
      push_line(1'b0, l1);
      wr_l1 = 1'b1;
      tick();
      wr_l1 = 1'b0;
      collect(4, "bp_head", t);
      ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold_byte", {24'h0, tx_byte}, 32'h30);
         chk("bp_hold_valid", {31'h0, tx_valid}, 1);
      end
      ready = 1'b1;
      collect(18, "bp_tail", t);
      tick();
      chk("bp_idle_ready", {31'h0, cmd_rdy}, 1);

      // Reset asserted at byte 10
      push_line(1'b0, l1);
      wr_l1 = 1'b1;
      tick();
      wr_l1 = 1'b0;
      collect(10, "mid", t);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'h0, tx_valid}, 0);
      chk("mid_rst_last",  {31'h0, tx_last}, 0);
      chk("mid_rst_byte",  {24'h0, tx_byte}, 0);
      chk("mid_rst_ready", {31'h0, cmd_rdy}, 1);
      sb.delete();
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_ready", {31'h0, cmd_rdy}, 1);
      chk("post_rst_valid", {31'h0, tx_valid}, 0);
      push_clear();
      wr_clr = 1'b1;
      tick();
      wr_clr = 1'b0;
      collect(3, "post_rst_clr", t);
      tick();
      chk("post_rst_clr_ready", {31'h0, cmd_rdy}, 1);

      // Non-printable text bytes
      l1 = {8'h07, "ABCDEFGHIJKLMN", 8'h7F};
      push_line(1'b0, l1);
      wr_l1 = 1'b1;
      tick();
      wr_l1 = 1'b0;
      collect(22, "flt", t);
      tick();

      // Default gap 25: clear takes 54 enabled ticks from accept to ready
      g_wr_clr = 1'b1;
      tick();
      g_wr_clr = 1'b0;
      chk("gap_first_valid", {31'h0, g_valid}, 1);
      chk("gap_first_byte", {24'h0, g_byte}, 32'h1B);
      tick();
      cnt = 1;
      chk("gap_valid_low", {31'h0, g_valid}, 0);
      while (!g_rdy && cnt < 300) begin
         tick();
         cnt++;
      end
      chk("gap_total_ticks", cnt, 54);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Command-to-byte-stream stage between the LCD text feed FSM and the SPI transmit master for the PMOD CLS display. Accepts one of three pulsed write commands (clear display, write line 1, write line 2) and snapshots the 16-character text for the selected line. Expands the command into a PMOD CLS escape sequence and streams it byte-by-byte over a valid/ready handshake, with a programmable inter-byte gap. Drives the command-ready flag that the feed FSM polls.

## Interface
- parm_gap_ce, default 25: idle clock-enable ticks inserted between accepted bytes; 0 means back-to-back bytes.
- i_clk_20mhz  in  1  system clock.
- i_rst_20mhz  in  1  reset; asynchronous and active-high.
- i_ce_2_5mhz  in  1  clock enable; all state, counter and handshake updates occur only on enabled edges.
- i_wr_clear_display  in  1  request clear-display command.
- i_wr_text_line1  in  1  request write of line 1.
- i_wr_text_line2  in  1  request write of line 2.
- i_dat_ascii_line1  in  128  line 1 text; char 0 in bits [127:120].
- i_dat_ascii_line2  in  128  line 2 text; same packing.
- o_command_ready  out  1  high only in ST_IDLE.
- o_tx_byte  out  8  byte offered to the SPI master.
- o_tx_valid  out  1  o_tx_byte is valid.
- i_tx_ready  in  1  SPI master accepts the byte.
- o_tx_last  out  1  qualifies the final byte of a command; SPI master deasserts CS after it.

## Operation
- States: ST_IDLE, ST_SEND, ST_GAP, ST_DONE.
- ST_IDLE: on an enabled edge with any write request, latch the command, snapshot the 128-bit text of the selected line, set the index to 0, and go to ST_SEND.
- Request priority: clear > line1 > line2. Losing requests are dropped, not queued.
- Sequences:
  - Clear: 0x1B 0x5B 0x6A (3 bytes).
  - Line 1: 0x1B 0x5B 0x30 0x3B 0x30 0x48, then 16 text bytes (22 bytes).
  - Line 2: same, with 0x31 as the third byte (22 bytes).
- Byte index is 5 bits; o_tx_last = (index == length-1) while o_tx_valid.
- ST_SEND: o_tx_valid=1. A transfer occurs on an enabled edge with o_tx_valid && i_tx_ready.
  - After the last byte: go to ST_DONE.
  - Otherwise, with parm_gap_ce>0: increment index, load the gap counter, go to ST_GAP.
  - Otherwise: increment index and stay in ST_SEND.
- ST_GAP: o_tx_valid=0. Count parm_gap_ce enabled ticks, then return to ST_SEND.
- ST_DONE: one enabled tick, then ST_IDLE.
- Text inputs may change freely after acceptance; only the snapshot is transmitted.

## Timing
- Reset values:
  - State ST_IDLE, so o_command_ready=1.
  - o_tx_valid=0, o_tx_byte=0x00, o_tx_last=0, index=0, gap counter=0.
- Accept edge → o_command_ready low and o_tx_valid high with byte 0 from the following clock.
- o_tx_byte, o_tx_valid and o_tx_last are registered. They hold stable while i_tx_ready is low (backpressure is unbounded).
- Per-byte cost: 1 + parm_gap_ce enabled ticks when i_tx_ready is held high.
- Clear command, gap 25, ready high: 3 + 2×25 + 1 = 54 ticks from accept to o_command_ready high.
- A request that arrives in a non-IDLE state is ignored; the feed FSM holds its request until it sees ready low.
- Reset asserted mid-sequence: outputs return to reset values immediately (asynchronously) and the sequence is abandoned. No partial byte is marked last.

## Configuration
- LCD_CMD_SEQ_CHAR_FILTER_EN defined: text bytes below 0x20 or above 0x7E are transmitted as 0x20; escape and position bytes are unaffected.
- Undefined: text bytes pass through raw.

## Structure
- Shared package lcd_cmd_pkg holds:
  - t_lcd_cmd_state enum.
  - t_lcd_line_text (logic [127:0]).
  - Escape byte constants c_esc, c_bracket, c_clear, c_semicolon, c_home.
  - Sequence lengths c_len_clear=3, c_len_line=22.
- One sub-module, lcd_char_filter: combinational byte substitution, instantiated only under the macro.

## Test plan
- Clear: pulse i_wr_clear_display with i_tx_ready=1 and gap 0 → bytes 0x1B, 0x5B, 0x6A on consecutive enabled ticks; o_tx_last on 0x6A; ready high one tick after DONE.
- Line 2 with text "X+0.12 Y-0.03 Z1" → 22 bytes: 0x1B 0x5B 0x31 0x3B 0x30 0x48, then the ASCII text; change the input mid-stream → transmitted text is unchanged.
- Clear and line1 asserted on the same edge → clear sequence only; line1 dropped.
- Hold i_tx_ready low for 10 ticks on byte 4 of line 1 → o_tx_byte stays 0x30 and valid stays high; no skipped or duplicated bytes.
- Reset asserted at byte 10 → o_tx_valid=0 immediately; o_command_ready=1 after release; a new clear runs cleanly.
- With the macro defined, text byte 0x07 → transmitted as 0x20; without the macro → transmitted as 0x07.
